load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the single-cycle datapath.
- Consumes the datapath's effective address (ALUResult) and store data (WriteData), plus control from the decoder.
- Runs a request/acknowledge transaction on a word-wide data bus with variable wait states.
- Returns sized, sign/zero-extended load data as ReadData and holds the core with Stall until the access retires.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/load_store_unit_if.sv | 28 ++
 rtl/lsu_align.sv | 51 +++++
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 tb/tb_load_store_unit.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - Funct3 encodings for access size/sign (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - lsu_state_t: FSM states IDLE, WAIT, DONE
//   - access_illegal(): legality check for a requested access
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Returns 1 for any access that must not reach the bus: load and store
    // together, a reserved size code, a store with the unsigned bit set, or a
    // halfword/word that is not naturally aligned.
    function automatic logic access_illegal(input logic       rd,
                                            input logic       wr,
                                            input logic [2:0] f3,
                                            input logic [1:0] off);
        logic bad;
        bad = rd & wr;
        case (f3)
            F3_B, F3_BU: ;
            F3_H, F3_HU: if (off[0]) bad = 1'b1;
            F3_W:        if (off != 2'b00) bad = 1'b1;
            default:     bad = 1'b1;
        endcase
        if (wr && f3[2]) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: word-wide request/acknowledge data bus.
// Handshake: the master raises bus_req together with stable bus_we,
// bus_addr, bus_wstrb and bus_wdata and holds all of them unchanged until the
// slave answers with a one-cycle bus_ack; on that same cycle bus_rdata is
// valid for reads. A request may be withdrawn without ack only by reset.
//   master modport: drives bus_req/we/addr/wstrb/wdata, receives bus_ack/rdata
//   slave modport : the reverse
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_wstrb;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic.
//   funct3_i : access size/sign code
//   offset_i : byte offset within the word (Addr[1:0])
//   wdata_i  : right-justified store data
//   rdata_i  : raw bus read word
//   wstrb_o  : byte-lane strobes for a store of this size at this offset
//   wdata_o  : store data replicated across all lanes
//   rdata_o  : selected byte/half, sign- or zero-extended (word passes through)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        wstrb_o = 4'b1111;
        wdata_o = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                wstrb_o = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                wstrb_o = 4'b0011 << offset_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Bring the addressed byte/half down to bit 0, then extend.
    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        case (funct3_i)
            F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata_o = {24'd0, shifted[7:0]};
            F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata_o = {16'd0, shifted[15:0]};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage behind the single-cycle datapath.
// Core side : MemRead/MemWrite/Funct3/Addr/WriteData in, ReadData/Stall/
//             AccessErr out; state_o exposes the FSM state for debug.
// Bus side  : load_store_unit_if.master (req/ack with wait states).
// clk/reset : reset is synchronous, active-low.
// Build option: define LSU_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without ack (parameter exists only then).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
`ifdef LSU_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [2:0]         Funct3,
    input  logic [ADDR_W-1:0]  Addr,
    input  logic [31:0]        WriteData,
    output logic [31:0]        ReadData,
    output logic               Stall,
    output logic               AccessErr,
    output lsu_state_t         state_o,
    load_store_unit_if.master  bus
);

    lsu_state_t        state_q, state_d;
    logic              req_q, we_q, err_q, load_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;

    logic              take_legal, take_bad, finish_ack, finish_abort;
    logic [2:0]        al_f3;
    logic [1:0]        al_off;
    logic [3:0]        al_wstrb;
    logic [31:0]       al_wdata, al_rdata;

    // In IDLE the aligner shapes the store from live inputs; in WAIT it
    // extracts load data using the size/offset latched at acceptance.
    assign al_f3  = (state_q == IDLE) ? Funct3    : f3_q;
    assign al_off = (state_q == IDLE) ? Addr[1:0] : off_q;

    lsu_align u_align (
        .funct3_i (al_f3),
        .offset_i (al_off),
        .wdata_i  (WriteData),
        .rdata_i  (bus.bus_rdata),
        .wstrb_o  (al_wstrb),
        .wdata_o  (al_wdata),
        .rdata_o  (al_rdata)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_hit;

    // cnt_q counts completed ack-less WAIT cycles; the current cycle is the
    // one that brings the count up to TIMEOUT_CYCLES.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset)                               cnt_q <= '0;
        else if (take_legal)                      cnt_q <= '0;
        else if (state_q == WAIT && !bus.bus_ack) cnt_q <= cnt_q + 1'b1;
    end
`else
    logic timeout_hit;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        Stall        = 1'b0;
        take_legal   = 1'b0;
        take_bad     = 1'b0;
        finish_ack   = 1'b0;
        finish_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    Stall = 1'b1;
                    if (access_illegal(MemRead, MemWrite, Funct3, Addr[1:0])) begin
                        take_bad = 1'b1;
                        state_d  = DONE;
                    end else begin
                        take_legal = 1'b1;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                Stall = 1'b1;
                // Ack takes priority over a simultaneous timeout.
                if (bus.bus_ack) begin
                    finish_ack = 1'b1;
                    state_d    = DONE;
                end else if (timeout_hit) begin
                    finish_abort = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wstrb_q <= 4'b0000;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            if (take_legal) begin
                req_q   <= 1'b1;
                we_q    <= MemWrite;
                addr_q  <= {Addr[ADDR_W-1:2], 2'b00};
                wstrb_q <= MemWrite ? al_wstrb : 4'b0000;
                wdata_q <= MemWrite ? al_wdata : 32'd0;
                err_q   <= 1'b0;
                load_q  <= MemRead;
                f3_q    <= Funct3;
                off_q   <= Addr[1:0];
            end
            if (take_bad) begin
                err_q   <= 1'b1;
                rdata_q <= 32'd0;
            end
            if (finish_ack) begin
                req_q   <= 1'b0;
                rdata_q <= load_q ? al_rdata : 32'd0;
            end
            if (finish_abort) begin
                req_q   <= 1'b0;
                err_q   <= 1'b1;
                rdata_q <= 32'd0;
            end
        end
    end

    assign ReadData      = rdata_q;
    assign AccessErr     = (state_q == DONE) && err_q;
    assign state_o       = state_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wstrb = wstrb_q;
    assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr, WriteData, ReadData;
    logic        Stall, AccessErr;
    lsu_state_t  state_o;

    load_store_unit_if #(.ADDR_W(32)) bus_if ();

    load_store_unit #(
        .ADDR_W(32)
`ifdef LSU_TIMEOUT_EN
        , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .AccessErr (AccessErr),
        .state_o   (state_o),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle outputs, set by the driver tasks.
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_aerr, exp_bus, exp_we, exp_chk_wdata;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic [3:0]  exp_strb;
    lsu_state_t  exp_state;

    // Observations gathered while comparing.
    int          run = 0, last_run = 0, req_cycles = 0, aerr_pulses = 0;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_strb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        chk("stall", 32'(Stall), 32'(exp_stall));
        chk("bus_req", 32'(bus_if.bus_req), 32'(exp_req));
        chk("access_err", 32'(AccessErr), 32'(exp_aerr));
        chk("read_data", ReadData, exp_rdata);
        chk("state", 32'(state_o), 32'(exp_state));
        if (exp_bus) begin
            chk("bus_we", 32'(bus_if.bus_we), 32'(exp_we));
            chk("bus_addr", bus_if.bus_addr, exp_addr);
            chk("bus_wstrb", 32'(bus_if.bus_wstrb), 32'(exp_strb));
            if (exp_chk_wdata) chk("bus_wdata", bus_if.bus_wdata, exp_wdata);
        end
        if (Stall) run++;
        else if (run != 0) begin
            last_run = run;
            run = 0;
        end
        if (bus_if.bus_req) begin
            req_cycles++;
            last_addr  = bus_if.bus_addr;
            last_strb  = bus_if.bus_wstrb;
            last_wdata = bus_if.bus_wdata;
        end
        if (AccessErr) aerr_pulses++;
    endtask

    // One clock: compare mid-cycle, then move to just after the next edge.
    task automatic tick();
        @(negedge clk);
        if (chk_en) compare_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour from the access rules, in plain arithmetic.
    task automatic model(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         output logic bad, output logic [3:0] strb,
                         output logic [31:0] wrep, output logic [31:0] rext);
        int sz, off, nbytes;
        logic [31:0] v;
        sz  = int'(f3) % 4;
        off = int'(a % 4);
        bad = (rd && wr) || f3 == 3'd3 || f3 >= 3'd6 || (wr && f3 >= 3'd4) ||
              (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
        nbytes = 1 << sz;
        strb = 4'(((1 << nbytes) - 1) << off);
        if (sz == 0)      wrep = (wd & 32'hFF) * 32'h01010101;
        else if (sz == 1) wrep = (wd & 32'hFFFF) * 32'h00010001;
        else              wrep = wd;
        v = rdat >> (8 * off);
        if (sz == 0) begin
            v = v & 32'hFF;
            if (f3 < 3'd4 && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 1) begin
            v = v & 32'hFFFF;
            if (f3 < 3'd4 && v >= 32'd32768) v = v - 32'd65536;
        end
        rext = v;
    endtask

    task automatic set_idle_exp();
        exp_stall = 1'b0; exp_req = 1'b0; exp_aerr = 1'b0; exp_bus = 1'b0;
        exp_state = IDLE;
    endtask

    task automatic idle(input int n);
        MemRead = 1'b0; MemWrite = 1'b0; bus_if.bus_ack = 1'b0;
        set_idle_exp();
        repeat (n) tick();
    endtask

    // Full access from an IDLE cycle; ack arrives after 'waits' empty WAIT cycles.
    // Stray acks are presented in IDLE and DONE to show they are ignored.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int waits);
        logic bad;
        logic [3:0] strb;
        logic [31:0] wrep, rext;
        model(rd, wr, f3, a, wd, rdat, bad, strb, wrep, rext);
        MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WriteData = wd;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = ~rdat;
        set_idle_exp();
        exp_stall = 1'b1;
        tick();
        if (!bad) begin
            for (int i = 0; i <= waits; i++) begin
                bus_if.bus_ack   = (i == waits);
                bus_if.bus_rdata = (i == waits) ? rdat : ~rdat;
                exp_stall = 1'b1; exp_req = 1'b1; exp_bus = 1'b1; exp_state = WAIT;
                exp_we = wr; exp_addr = a & ~32'd3;
                exp_strb = wr ? strb : 4'b0000;
                exp_wdata = wrep; exp_chk_wdata = wr;
                tick();
            end
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hA5A5A5A5;
        set_idle_exp();
        exp_state = DONE;
        exp_aerr  = bad;
        exp_rdata = (rd && !bad) ? rext : 32'd0;
        tick();
        bus_if.bus_ack = 1'b0;
        set_idle_exp();
    endtask

    int rc0, ae0;

    initial begin
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
        Addr = 32'd0; WriteData = 32'd0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_o), 32'(IDLE));
        chk("rst_req", 32'(bus_if.bus_req), 32'd0);
        chk("rst_we", 32'(bus_if.bus_we), 32'd0);
        chk("rst_wstrb", 32'(bus_if.bus_wstrb), 32'd0);
        chk("rst_addr", bus_if.bus_addr, 32'd0);
        chk("rst_wdata", bus_if.bus_wdata, 32'd0);
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_err", 32'(AccessErr), 32'd0);
        reset = 1'b1;
        exp_rdata = 32'd0;
        chk_en = 1'b1;
        idle(2);

        // sw with two wait states
        ae0 = aerr_pulses;
        access(1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 32'd0, 2);
        chk("sw_stall_run", 32'(last_run), 32'd4);
        chk("sw_addr", last_addr, 32'h100);
        chk("sw_strb", 32'(last_strb), 32'b1111);
        chk("sw_wdata", last_wdata, 32'hDEADBEEF);
        chk("sw_noerr", 32'(aerr_pulses - ae0), 32'd0);

        // lb / lbu at offset 3, immediate ack
        access(1'b1, 1'b0, F3_B, 32'h203, 32'd0, 32'h80AA55CC, 0);
        chk("lb_data", ReadData, 32'hFFFFFF80);
        chk("lb_stall_run", 32'(last_run), 32'd2);
        access(1'b1, 1'b0, F3_BU, 32'h203, 32'd0, 32'h80AA55CC, 0);
        chk("lbu_data", ReadData, 32'h00000080);

        // sh upper half
        access(1'b0, 1'b1, F3_H, 32'h302, 32'h1234ABCD, 32'd0, 1);
        chk("sh_strb", 32'(last_strb), 32'b1100);
        chk("sh_wdata", last_wdata, 32'hABCDABCD);
        chk("sh_addr", last_addr, 32'h300);
        chk("sh_rdata_zero", ReadData, 32'd0);

        // misaligned lw: error, no bus cycle
        rc0 = req_cycles; ae0 = aerr_pulses;
        access(1'b1, 1'b0, F3_W, 32'h101, 32'd0, 32'hFFFFFFFF, 0);
        chk("lw_mis_noreq", 32'(req_cycles - rc0), 32'd0);
        chk("lw_mis_err", 32'(aerr_pulses - ae0), 32'd1);
        chk("lw_mis_run", 32'(last_run), 32'd1);
        chk("lw_mis_rdata", ReadData, 32'd0);

        // more legal patterns, back to back
        access(1'b1, 1'b0, F3_H, 32'h206, 32'd0, 32'h80011234, 0);
        chk("lh_data", ReadData, 32'hFFFF8001);
        access(1'b0, 1'b1, F3_B, 32'h3, 32'h0000005A, 32'd0, 0);
        chk("sb_strb", 32'(last_strb), 32'b1000);
        chk("sb_wdata", last_wdata, 32'h5A5A5A5A);
        access(1'b1, 1'b0, F3_BU, 32'h1, 32'd0, 32'h0000FF00, 3);
        chk("lbu1_data", ReadData, 32'h000000FF);
        access(1'b1, 1'b0, F3_W, 32'h0, 32'd0, 32'h12345678, 1);
        chk("lw_data", ReadData, 32'h12345678);

        // illegal encodings
        rc0 = req_cycles; ae0 = aerr_pulses;
        access(1'b1, 1'b0, F3_H, 32'h1, 32'd0, 32'd0, 0);
        access(1'b1, 1'b1, F3_W, 32'h0, 32'd0, 32'd0, 0);
        access(1'b1, 1'b0, 3'b011, 32'h0, 32'd0, 32'd0, 0);
        access(1'b0, 1'b1, 3'b100, 32'h0, 32'd0, 32'd0, 0);
        access(1'b0, 1'b1, F3_W, 32'h2, 32'd0, 32'd0, 0);
        access(1'b1, 1'b0, 3'b111, 32'h0, 32'd0, 32'd0, 0);
        chk("illegal_noreq", 32'(req_cycles - rc0), 32'd0);
        chk("illegal_errs", 32'(aerr_pulses - ae0), 32'd6);
        idle(1);

        // reset while waiting for ack
        MemRead = 1'b1; Funct3 = F3_W; Addr = 32'h500; bus_if.bus_ack = 1'b0;
        set_idle_exp(); exp_stall = 1'b1;
        tick();
        exp_req = 1'b1; exp_bus = 1'b1; exp_we = 1'b0; exp_addr = 32'h500;
        exp_strb = 4'b0000; exp_chk_wdata = 1'b0; exp_state = WAIT;
        tick();
        tick();
        chk_en = 1'b0;
        reset = 1'b0; MemRead = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rstmid_req", 32'(bus_if.bus_req), 32'd0);
        chk("rstmid_state", 32'(state_o), 32'(IDLE));
        chk("rstmid_stall", 32'(Stall), 32'd0);
        exp_rdata = 32'd0;
        chk_en = 1'b1;
        run = 0;
        idle(1);
        access(1'b1, 1'b0, F3_HU, 32'h2, 32'd0, 32'hF00D0000, 0);
        chk("lhu_data", ReadData, 32'h0000F00D);

        // no ack at all
        MemRead = 1'b1; Funct3 = F3_W; Addr = 32'h600; bus_if.bus_ack = 1'b0;
        set_idle_exp(); exp_stall = 1'b1;
        tick();
        exp_req = 1'b1; exp_bus = 1'b1; exp_we = 1'b0; exp_addr = 32'h600;
        exp_strb = 4'b0000; exp_chk_wdata = 1'b0; exp_state = WAIT;
`ifdef LSU_TIMEOUT_EN
        ae0 = aerr_pulses;
        repeat (4) tick();
        MemRead = 1'b0;
        set_idle_exp(); exp_state = DONE; exp_aerr = 1'b1; exp_rdata = 32'd0;
        tick();
        idle(1);
        chk("timeout_run", 32'(last_run), 32'd5);
        chk("timeout_err", 32'(aerr_pulses - ae0), 32'd1);
`else
        repeat (20) tick();
        chk("hang_run", 32'(run), 32'd21);
        chk_en = 1'b0;
        reset = 1'b0; MemRead = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("hang_rst_stall", 32'(Stall), 32'd0);
        exp_rdata = 32'd0;
        chk_en = 1'b1;
        run = 0;
        idle(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
